traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Demand-driven phase scheduler for an N-approach junction (generalises the 2-way light FSM).
//  - Round-robin arbitration among approaches raising a vehicle request.
//  - Sizes each green from that approach's vehicle count, then sequences GREEN->YELLOW->ALLRED.
//  - Drives per-approach lamp codes; sits between the vehicle counters and the lamp drivers.
// PARAMETERS
//  N_APPROACH  4   number of approaches (2..8)
//  CNT_W       4   width of each per-approach vehicle count
//  GREEN_MIN   3   minimum green, seconds (>=1)
//  GREEN_MAX   15  maximum green, seconds (<=31)
//  YELLOW_T    3   yellow time, seconds (>=1)
//  ALLRED_T    1   all-red clearance, seconds (>=1)
// PORTS
//  clk_1Hz       in   1               1 Hz tick clock; all state changes on rising edge
//  reset         in   1               asynchronous, active-high
//  count         in   N_APPROACH*CNT_W  packed vehicle counts; approach i = count[i*CNT_W +: CNT_W]
//  req           in   N_APPROACH      per-approach demand (level)
//  light_st      out  3*N_APPROACH    approach i = light_st[3i +: 3]; 001 green, 010 yellow, 100 red
//  active_idx    out  3               approach currently granted (zero-extended)
//  phase_timer   out  5               seconds remaining in current phase, minus 1
// BEHAVIOUR
//  - States: ALLRED, GREEN, YELLOW. Registered: state, active_idx, phase_timer, last_grant.
//  - Reset (async): state=ALLRED, phase_timer=ALLRED_T-1, active_idx=0, last_grant=N_APPROACH-1.
//    All light_st lanes = 100.
//  - light_st is a combinational decode of the registered state/active_idx:
//    - active lane = 001 in GREEN, 010 in YELLOW, 100 in ALLRED; all other lanes always 100.
//    - Never two non-red lanes at once.
//  - Timer: loads (duration-1) on phase entry; decrements by 1 each edge while >0.
//    The phase ends on the edge where it reads 0.
//  - ALLRED at timer 0:
//    - Search req starting at last_grant+1, wrapping modulo N_APPROACH.
//    - First set bit g: next state GREEN, active_idx=g, last_grant=g, timer=D(g)-1.
//    - No req: stay ALLRED, timer held at 0; re-evaluate every edge.
//  - D(g) = clamp(count[g], GREEN_MIN, GREEN_MAX), sampled once at grant.
//    Count changes during green are ignored. count=0 gives GREEN_MIN.
//  - GREEN at timer 0:
//    - Any req set other than active_idx: go YELLOW, timer=YELLOW_T-1.
//    - Otherwise rest in GREEN, timer held at 0. Leave to YELLOW on the first edge a competing req is seen.
//  - YELLOW at timer 0: go ALLRED, timer=ALLRED_T-1.
//  - Green always completes its latched D(g), even if req[g] drops mid-green.
//  - Own-approach req during its own green is ignored; it is served again only via round-robin.
//  - Simultaneous reqs: round-robin order only; lowest index wins on the first grant after reset.
//  - Reset mid-phase: immediate all red, sequence restarts from ALLRED.
//  - Cycle bound: no approach waits more than (N_APPROACH-1)*(GREEN_MAX+YELLOW_T+ALLRED_T)+ALLRED_T s.
// CONFIGURATION
//  EMERGENCY_PREEMPT_EN defined adds two ports:
//    - preempt (in, N_APPROACH): per-approach preempt request.
//    - preempt_active (out, 1): registered; 1 from preempt grant until that green ends.
//  Preempt behaviour (macro defined):
//    - Any preempt set for an approach != active_idx while in GREEN: go YELLOW next edge.
//      The remaining green, including GREEN_MIN, is waived.
//    - Next ALLRED exit grants the lowest-index preempting approach, ignoring round-robin and req.
//    - Preempted green holds (timer at 0) while its preempt is high.
//      It ends via YELLOW once preempt drops, or at once if D has elapsed.
//    - last_grant is unchanged by a preempt grant.
//    - preempt during YELLOW or ALLRED does not shorten those phases.
//    - preempt_active resets to 0.
//  Macro undefined: preempt and preempt_active ports are absent; the rules above are all that apply.
// TESTING
//  1 Reset pulse at t=2.5s with req=0: all lanes 100, active_idx=0; stays ALLRED indefinitely, timer=0.
//  2 req=0101, count0=7, count2=2:
//    - Lane0 green 7 s, yellow 3 s, all-red 1 s.
//    - Then lane2 green 3 s (GREEN_MIN), yellow 3, red 1.
//    - Then lane0 again.
//  3 req=0001 only, count0=20: lane0 green 15 s (GREEN_MAX), then rests green.
//    - Raise req[3]: yellow on the next edge; lane3 green after 3+1 s.
//  4 req=1111 constant: grants 0,1,2,3,0 in order; never two non-red lanes.
//    - Checker asserts the starvation bound.
//  5 Assert reset mid-YELLOW on lane1: all lanes 100 on the same edge.
//    - Next grant starts search at lane0.
//  6 (EMERGENCY_PREEMPT_EN) Lane0 green 2 s into a 10 s green; preempt=0100:
//    - Lane0 yellow next edge, then lane2 green, preempt_active=1, held while preempt high.
//    - After release: yellow, and round-robin resumes at lane1.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-driven round-robin phase scheduler for an N-approach junction
// Optional feature macro: EMERGENCY_PREEMPT_EN (adds preempt input and preempt_active output).
module traffic_phase_scheduler #(
    parameter int N_APPROACH = 4,
    parameter int CNT_W      = 4,
    parameter int GREEN_MIN  = 3,
    parameter int GREEN_MAX  = 15,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1
) (
    input  logic                          clk_1Hz,
    input  logic                          reset,
    input  logic [N_APPROACH*CNT_W-1:0]   count,
    input  logic [N_APPROACH-1:0]         req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic [N_APPROACH-1:0]         preempt,
    output logic                          preempt_active,
`endif
    output logic [3*N_APPROACH-1:0]       light_st,
    output logic [2:0]                    active_idx,
    output logic [4:0]                    phase_timer
);

    typedef enum logic [1:0] {ST_ALLRED = 2'd0, ST_GREEN = 2'd1, ST_YELLOW = 2'd2} state_t;

    localparam logic [4:0] T_YELLOW = 5'(YELLOW_T - 1);
    localparam logic [4:0] T_ALLRED = 5'(ALLRED_T - 1);
    localparam logic [2:0] LAST_RST = 3'(N_APPROACH - 1);

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_active_idx, w_active_nxt;
    logic [2:0]            r_last_grant, w_last_nxt;
    logic [4:0]            r_phase_timer, w_timer_nxt, w_timer_dec, w_green_load;
    logic                  w_timer_zero, w_competing;
    logic [N_APPROACH-1:0] w_active_oh;
    logic                  w_rr_hi_found, w_rr_lo_found, w_rr_found;
    logic [2:0]            w_rr_hi_idx, w_rr_lo_idx, w_rr_idx, w_grant_idx;
    logic [CNT_W-1:0]      w_grant_cnt;
    logic [31:0]           w_grant_cnt_ext;
`ifdef EMERGENCY_PREEMPT_EN
    logic                  r_preempt_active, w_pa_nxt;
    logic                  w_pe_found, w_pe_other, w_pe_own;
    logic [2:0]            w_pe_idx;
`endif

    assign w_timer_zero = (r_phase_timer == 5'd0);
    assign w_timer_dec  = w_timer_zero ? 5'd0 : r_phase_timer - 5'd1;

    // Round-robin: lowest requester above last_grant, else lowest at or below it.
    always_comb begin
        w_rr_hi_found = 1'b0;
        w_rr_lo_found = 1'b0;
        w_rr_hi_idx   = '0;
        w_rr_lo_idx   = '0;
        w_active_oh   = '0;
        for (int i = N_APPROACH - 1; i >= 0; i--) begin
            if (3'(i) == r_active_idx) w_active_oh[i] = 1'b1;
            if (req[i]) begin
                if (3'(i) > r_last_grant) begin
                    w_rr_hi_found = 1'b1;
                    w_rr_hi_idx   = 3'(i);
                end else begin
                    w_rr_lo_found = 1'b1;
                    w_rr_lo_idx   = 3'(i);
                end
            end
        end
        w_rr_found  = w_rr_hi_found | w_rr_lo_found;
        w_rr_idx    = w_rr_hi_found ? w_rr_hi_idx : w_rr_lo_idx;
        w_competing = |(req & ~w_active_oh);
    end

`ifdef EMERGENCY_PREEMPT_EN
    always_comb begin
        w_pe_found = 1'b0;
        w_pe_idx   = '0;
        for (int i = N_APPROACH - 1; i >= 0; i--) begin
            if (preempt[i]) begin
                w_pe_found = 1'b1;
                w_pe_idx   = 3'(i);
            end
        end
        w_pe_other  = |(preempt & ~w_active_oh);
        w_pe_own    = |(preempt & w_active_oh);
        w_grant_idx = w_pe_found ? w_pe_idx : w_rr_idx;
    end
`else
    assign w_grant_idx = w_rr_idx;
`endif

    // Green length is the granted approach's count clamped to [GREEN_MIN, GREEN_MAX].
    always_comb begin
        w_grant_cnt = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            if (3'(i) == w_grant_idx) w_grant_cnt = count[i*CNT_W +: CNT_W];
        end
        w_grant_cnt_ext = 32'(w_grant_cnt);
        if (w_grant_cnt_ext < 32'(GREEN_MIN))
            w_green_load = 5'(GREEN_MIN - 1);
        else if (w_grant_cnt_ext > 32'(GREEN_MAX))
            w_green_load = 5'(GREEN_MAX - 1);
        else
            w_green_load = 5'(w_grant_cnt_ext - 32'd1);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active_idx;
        w_last_nxt   = r_last_grant;
        w_timer_nxt  = w_timer_dec;
`ifdef EMERGENCY_PREEMPT_EN
        w_pa_nxt     = r_preempt_active;
`endif
        case (r_state)
            ST_ALLRED: begin
                if (w_timer_zero) begin
`ifdef EMERGENCY_PREEMPT_EN
                    if (w_pe_found) begin
                        w_state_nxt  = ST_GREEN;
                        w_active_nxt = w_pe_idx;
                        w_timer_nxt  = w_green_load;
                        w_pa_nxt     = 1'b1;
                    end else
`endif
                    if (w_rr_found) begin
                        w_state_nxt  = ST_GREEN;
                        w_active_nxt = w_rr_idx;
                        w_last_nxt   = w_rr_idx;
                        w_timer_nxt  = w_green_load;
                    end
                end
            end
            ST_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
                if (w_pe_other) begin
                    w_state_nxt = ST_YELLOW;
                    w_timer_nxt = T_YELLOW;
                    w_pa_nxt    = 1'b0;
                end else if (w_timer_zero && !(r_preempt_active && w_pe_own) &&
                             (r_preempt_active || w_competing)) begin
                    w_state_nxt = ST_YELLOW;
                    w_timer_nxt = T_YELLOW;
                    w_pa_nxt    = 1'b0;
                end
`else
                if (w_timer_zero && w_competing) begin
                    w_state_nxt = ST_YELLOW;
                    w_timer_nxt = T_YELLOW;
                end
`endif
            end
            ST_YELLOW: begin
                if (w_timer_zero) begin
                    w_state_nxt = ST_ALLRED;
                    w_timer_nxt = T_ALLRED;
                end
            end
            default: begin
                w_state_nxt = ST_ALLRED;
                w_timer_nxt = T_ALLRED;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ALLRED;
            r_active_idx  <= 3'd0;
            r_last_grant  <= LAST_RST;
            r_phase_timer <= T_ALLRED;
        end else begin
            r_state       <= w_state_nxt;
            r_active_idx  <= w_active_nxt;
            r_last_grant  <= w_last_nxt;
            r_phase_timer <= w_timer_nxt;
        end
    end

`ifdef EMERGENCY_PREEMPT_EN
    always_ff @(posedge clk_1Hz or posedge reset) begin
        if (reset) r_preempt_active <= 1'b0;
        else       r_preempt_active <= w_pa_nxt;
    end

    assign preempt_active = r_preempt_active;
`endif

    always_comb begin
        light_st = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            light_st[3*i +: 3] = 3'b100;
            if (3'(i) == r_active_idx) begin
                if (r_state == ST_GREEN)       light_st[3*i +: 3] = 3'b001;
                else if (r_state == ST_YELLOW) light_st[3*i +: 3] = 3'b010;
            end
        end
    end

    assign active_idx  = r_active_idx;
    assign phase_timer = r_phase_timer;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [11:0] ALL_RED = 12'b100100100100;
    localparam int STARVE_BOUND = 3 * (15 + 3 + 1) + 1;

    logic        clk_1Hz;
    logic        reset;
    logic [19:0] count;
    logic [3:0]  req;
    logic [11:0] light_st;
    logic [2:0]  active_idx;
    logic [4:0]  phase_timer;
`ifdef EMERGENCY_PREEMPT_EN
    logic [3:0]  preempt;
    logic        preempt_active;
`endif

    int n_vec = 0;
    int n_err = 0;

    int got [5];
    int n_got, nonred, max_nonred, max_wait;
    int wait_s [4];
    logic [3:0] prev_g;
    logic [2:0] lane;
    logic found;

    traffic_phase_scheduler #(.CNT_W(5)) dut (
        .clk_1Hz     (clk_1Hz),
        .reset       (reset),
        .count       (count),
        .req         (req),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt        (preempt),
        .preempt_active (preempt_active),
`endif
        .light_st    (light_st),
        .active_idx  (active_idx),
        .phase_timer (phase_timer)
    );

    initial begin
        clk_1Hz = 1'b0;
        forever #5 clk_1Hz = ~clk_1Hz;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] lamp(input int idx, input logic [2:0] code);
        logic [11:0] v;
        v = ALL_RED;
        v[3*idx +: 3] = code;
        return v;
    endfunction

    function automatic logic [19:0] cnts(input int c3, input int c2, input int c1, input int c0);
        return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1Hz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [11:0] exp_light,
                            input int exp_idx, input int exp_timer);
        check({tag, "/light"}, 32'(light_st), 32'(exp_light));
        check({tag, "/idx"}, 32'(active_idx), 32'(exp_idx));
        check({tag, "/timer"}, 32'(phase_timer), 32'(exp_timer));
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        count = '0;
`ifdef EMERGENCY_PREEMPT_EN
        preempt = '0;
`endif
        // reset with no demand, then idle all-red
        #2 reset = 1'b1;
        #1 check_st("rst", ALL_RED, 0, 0);
        #4 reset = 1'b0;
        tick(5);
        check_st("idle", ALL_RED, 0, 0);

        // lane0 (7 s) and lane2 (GREEN_MIN) alternate
        count = cnts(0, 2, 0, 7);
        req   = 4'b0101;
        tick(1);  check_st("l0_grant", lamp(0, G), 0, 6);
        tick(6);  check_st("l0_end", lamp(0, G), 0, 0);
        tick(1);  check_st("l0_yel", lamp(0, Y), 0, 2);
        tick(3);  check_st("l0_red", ALL_RED, 0, 0);
        tick(1);  check_st("l2_grant", lamp(2, G), 2, 2);
        tick(2);  check_st("l2_end", lamp(2, G), 2, 0);
        tick(1);  check_st("l2_yel", lamp(2, Y), 2, 2);
        tick(3);  check_st("l2_red", ALL_RED, 2, 0);
        tick(1);  check_st("l0_again", lamp(0, G), 0, 6);

        // GREEN_MAX clamp, rest in green, competing request
        reset = 1'b1;
        #1 check_st("rst2", ALL_RED, 0, 0);
        reset = 1'b0;
        count = cnts(0, 0, 0, 20);
        req   = 4'b0001;
        tick(1);  check_st("max_grant", lamp(0, G), 0, 14);
        tick(14); check_st("max_end", lamp(0, G), 0, 0);
        tick(3);  check_st("rest", lamp(0, G), 0, 0);
        req = 4'b1001;
        tick(1);  check_st("rest_yel", lamp(0, Y), 0, 2);
        tick(3);  check_st("rest_red", ALL_RED, 0, 0);
        tick(1);  check_st("l3_grant", lamp(3, G), 3, 2);

        // all requesting: order, exclusivity, starvation bound
        req   = 4'b1111;
        count = cnts(0, 0, 0, 0);
        for (int k = 0; k < 5; k++) got[k] = 9;
        for (int i = 0; i < 4; i++) begin
            wait_s[i] = 0;
            prev_g[i] = (light_st[3*i +: 3] == G);
        end
        n_got = 0;
        max_nonred = 0;
        max_wait = 0;
        for (int e = 0; e < 40; e++) begin
            tick(1);
            nonred = 0;
            for (int i = 0; i < 4; i++) begin
                lane = light_st[3*i +: 3];
                if (lane != R) nonred++;
                if (lane == G) begin
                    if (!prev_g[i] && n_got < 5) begin
                        got[n_got] = i;
                        n_got++;
                    end
                    wait_s[i] = 0;
                    prev_g[i] = 1'b1;
                end else begin
                    wait_s[i]++;
                    prev_g[i] = 1'b0;
                    if (wait_s[i] > max_wait) max_wait = wait_s[i];
                end
            end
            if (nonred > max_nonred) max_nonred = nonred;
        end
        check("rr0", 32'(got[0]), 0);
        check("rr1", 32'(got[1]), 1);
        check("rr2", 32'(got[2]), 2);
        check("rr3", 32'(got[3]), 3);
        check("rr4", 32'(got[4]), 0);
        check("one_nonred", 32'(max_nonred), 1);
        check("starve", 32'(max_wait <= STARVE_BOUND), 1);

        // reset while lane1 is yellow
        found = 1'b0;
        for (int e = 0; e < 30 && !found; e++) begin
            tick(1);
            if (light_st == lamp(1, Y)) found = 1'b1;
        end
        check("l1_yel_seen", 32'(light_st), 32'(lamp(1, Y)));
        reset = 1'b1;
        #1 check_st("rst_mid", ALL_RED, 0, 0);
        reset = 1'b0;
        tick(1);  check_st("post_rst", lamp(0, G), 0, 2);

`ifdef EMERGENCY_PREEMPT_EN
        // preempt lane2 two seconds into a 10 s lane0 green
        reset = 1'b1;
        #1 check("pa_rst", 32'(preempt_active), 0);
        reset = 1'b0;
        count = cnts(0, 4, 0, 10);
        req   = 4'b0011;
        tick(1);  check_st("pe_l0", lamp(0, G), 0, 9);
        tick(2);  check_st("pe_l0_2s", lamp(0, G), 0, 7);
        preempt = 4'b0100;
        tick(1);  check_st("pe_yel", lamp(0, Y), 0, 2);
        tick(3);  check_st("pe_red", ALL_RED, 0, 0);
        tick(1);  check_st("pe_grant", lamp(2, G), 2, 3);
        check("pa_on", 32'(preempt_active), 1);
        tick(6);  check_st("pe_hold", lamp(2, G), 2, 0);
        check("pa_hold", 32'(preempt_active), 1);
        preempt = 4'b0000;
        tick(1);  check_st("pe_rel", lamp(2, Y), 2, 2);
        check("pa_off", 32'(preempt_active), 0);
        tick(3);  check_st("pe_red2", ALL_RED, 2, 0);
        tick(1);  check_st("pe_resume", lamp(1, G), 1, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
